// File: rtl/frame_config_sequencer_pkg.sv
// Shared types and header layout for the frame configuration sequencer.
// A header word carries magic, target column, start frame and frame count.
package frame_cfg_pkg;

    typedef enum logic [2:0] {IDLE, SKIP, LOAD, STROBE, HOLD} state_e;

    localparam logic [3:0]  HDR_MAGIC     = 4'hA;
    localparam int unsigned HDR_MAGIC_LSB = 28;
    localparam int unsigned HDR_MAGIC_W   = 4;
    localparam int unsigned HDR_COL_LSB   = 20;
    localparam int unsigned HDR_COL_W     = 8;
    localparam int unsigned HDR_START_LSB = 12;
    localparam int unsigned HDR_START_W   = 8;
    localparam int unsigned HDR_COUNT_LSB = 0;
    localparam int unsigned HDR_COUNT_W   = 12;

    typedef struct packed {
        logic [HDR_MAGIC_W-1:0] magic;
        logic [HDR_COL_W-1:0]   column;
        logic [HDR_START_W-1:0] start;
        logic [HDR_COUNT_W-1:0] count;
    } hdr_t;

    function automatic hdr_t parse_header(input logic [31:0] w);
        hdr_t h;
        h.magic  = w[HDR_MAGIC_LSB +: HDR_MAGIC_W];
        h.column = w[HDR_COL_LSB +: HDR_COL_W];
        h.start  = w[HDR_START_LSB +: HDR_START_W];
        h.count  = w[HDR_COUNT_LSB +: HDR_COUNT_W];
        return h;
    endfunction

endpackage

// File: rtl/frame_config_sequencer_if.sv
// Valid/ready configuration word stream feeding the sequencer.
interface frame_config_sequencer_if #(
    parameter int unsigned DataWidth = 32
);
    logic [DataWidth-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_config_sequencer_strobe_decoder.sv
// Frame index to one-hot strobe decoder, all-zero when disabled or out of range.
module frame_strobe_decoder #(
    parameter int unsigned NumLines = 20,
    parameter int unsigned IdxWidth = 8
) (
    input  logic [IdxWidth-1:0] idx_i,
    input  logic                en_i,
    output logic [NumLines-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < NumLines; i++) begin
            onehot_o[i] = en_i && (idx_i == IdxWidth'(i));
        end
    end

endmodule

// File: rtl/frame_config_sequencer.sv
// Parses column headers and writes the following data words into frame latches,
// holding each one-hot strobe for StrobeCycles cycles plus one hold cycle.
module frame_config_sequencer
    import frame_cfg_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned StrobeCycles    = 2,
    parameter logic [7:0]  ColumnId        = 8'd0
) (
    input  logic                       CLK,
    input  logic                       resetn,
    frame_config_sequencer_if.slave    cfg,
    input  logic                       err_clr,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned CntW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(StrobeCycles - 1);

    state_e                     state_q;
    logic [7:0]                 idx_q;
    logic [11:0]                remaining_q;
    logic [CntW-1:0]            cnt_q;
    logic [FrameBitsPerRow-1:0] data_q;
    logic [MaxFramesPerCol-1:0] strobe_q;
    logic                       ready_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       err_q;

    logic                       accept;
    hdr_t                       hdr;
    logic [12:0]                hdr_end;
    logic                       hdr_bad_magic;
    logic                       hdr_col_match;
    logic                       hdr_range_bad;
    logic                       err_set;
    logic [MaxFramesPerCol-1:0] strobe_d;

    // start+count is formed in 13 bits so an oversized count cannot wrap past the check
    always_comb begin
        accept        = cfg.s_valid && ready_q;
        hdr           = parse_header(cfg.s_data[31:0]);
        hdr_end       = {5'd0, hdr.start} + {1'b0, hdr.count};
        hdr_bad_magic = (hdr.magic != HDR_MAGIC);
        hdr_col_match = (hdr.column == ColumnId);
        hdr_range_bad = (hdr_end > 13'(MaxFramesPerCol));
        err_set       = accept && (state_q == IDLE)
                        && (hdr_bad_magic || (hdr_col_match && hdr_range_bad));
    end

    frame_strobe_decoder #(
        .NumLines (MaxFramesPerCol),
        .IdxWidth (8)
    ) u_strobe_dec (
        .idx_i    (idx_q),
        .en_i     (state_q == LOAD),
        .onehot_o (strobe_d)
    );

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            remaining_q <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            strobe_q    <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= err_set | (err_q & ~err_clr);
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept && !hdr_bad_magic) begin
                        if (!hdr_col_match || hdr_range_bad) begin
                            // Foreign or rejected group: swallow its data words
                            remaining_q <= hdr.count;
                            if (hdr.count != '0) begin
                                state_q <= SKIP;
                                busy_q  <= 1'b1;
                            end
                        end else if (hdr.count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            idx_q       <= hdr.start;
                            remaining_q <= hdr.count;
                            state_q     <= LOAD;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                SKIP: begin
                    if (accept) begin
                        remaining_q <= remaining_q - 12'd1;
                        if (remaining_q == 12'd1) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        data_q   <= cfg.s_data;
                        strobe_q <= strobe_d;
                        cnt_q    <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= STROBE;
                    end
                end
                STROBE: begin
                    if (cnt_q == CntLast) begin
                        strobe_q <= '0;
                        state_q  <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    idx_q       <= idx_q + 8'd1;
                    remaining_q <= remaining_q - 12'd1;
                    ready_q     <= 1'b1;
                    if (remaining_q == 12'd1) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg.s_ready  = ready_q;
    assign FrameData    = data_q;
    assign FrameStrobe  = strobe_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed bench for frame_config_sequencer with a frame-timer reference model.
module tb_frame_config_sequencer;

    localparam int unsigned NF  = 20;
    localparam int unsigned DW  = 32;
    localparam int          SC  = 2;
    localparam logic [7:0]  COL = 8'd0;

    logic          CLK     = 1'b0;
    logic          resetn  = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] FrameData;
    logic [NF-1:0] FrameStrobe;
    logic          busy;
    logic          done;
    logic          err;

    frame_config_sequencer_if #(.DataWidth(DW)) bus ();

    frame_config_sequencer #(
        .MaxFramesPerCol (NF),
        .FrameBitsPerRow (DW),
        .StrobeCycles    (SC),
        .ColumnId        (COL)
    ) dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .cfg         (bus),
        .err_clr     (err_clr),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    // Reference model: mode 0 idle, 1 skip, 2 group active; m_ft counts cycles since a data word was taken
    int            m_mode   = 0;
    int            m_ft     = 0;
    int            m_idx    = 0;
    int            m_rem    = 0;
    logic          m_ready  = 1'b0;
    logic          m_busy   = 1'b0;
    logic          m_done   = 1'b0;
    logic          m_err    = 1'b0;
    logic [31:0]   m_data   = '0;
    logic [NF-1:0] m_strobe = '0;

    always @(posedge CLK) begin : model_b
        logic        acc;
        logic        enew;
        logic [31:0] w;
        int          mg, col, st, n;
        acc  = bus.s_valid && m_ready;
        w    = bus.s_data;
        enew = 1'b0;
        if (!resetn) begin
            m_mode = 0; m_ft = 0; m_idx = 0; m_rem = 0;
            m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_data = '0; m_strobe = '0;
        end else begin
            m_done = 1'b0;
            if (m_ft != 0) begin
                m_ft++;
                if (m_ft == SC + 1) m_strobe = '0;
                if (m_ft == SC + 2) begin
                    m_ft = 0;
                    m_idx++;
                    m_rem--;
                    if (m_rem == 0) begin
                        m_done = 1'b1;
                        m_mode = 0;
                    end
                end
            end else if (acc) begin
                if (m_mode == 0) begin
                    mg  = int'(w >> 28);
                    col = int'((w >> 20) & 32'hFF);
                    st  = int'((w >> 12) & 32'hFF);
                    n   = int'(w & 32'hFFF);
                    if (mg != 10) begin
                        enew = 1'b1;
                    end else if (col != int'(COL) || st + n > int'(NF)) begin
                        if (col == int'(COL)) enew = 1'b1;
                        if (n > 0) begin
                            m_mode = 1;
                            m_rem  = n;
                        end
                    end else if (n == 0) begin
                        m_done = 1'b1;
                    end else begin
                        m_mode = 2;
                        m_idx  = st;
                        m_rem  = n;
                    end
                end else if (m_mode == 1) begin
                    m_rem--;
                    if (m_rem == 0) m_mode = 0;
                end else begin
                    m_data   = w;
                    m_strobe = NF'(1) << m_idx;
                    m_ft     = 1;
                end
            end
            m_err   = enew ? 1'b1 : (err_clr ? 1'b0 : m_err);
            m_ready = (m_ft == 0);
            m_busy  = (m_mode != 0);
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic        chk_en = 1'b0;
    int          pin_req = 0, pin_seen = 0, pin_id = 0;
    int          to_req = 0, to_seen = 0;
    int          scnt[NF];
    int          first_cyc[NF];
    logic [31:0] data_at[NF];
    int          done_cnt = 0;
    int          strobe_tot = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_pin(input int id);
        case (id)
            0: begin
                for (int i = 0; i < int'(NF); i++) begin
                    scnt[i] = 0; first_cyc[i] = -1; data_at[i] = '0;
                end
                done_cnt = 0; strobe_tot = 0;
            end
            1: begin
                chk("rst_FrameStrobe", 32'(FrameStrobe), 32'd0);
                chk("rst_FrameData", FrameData, 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
                chk("rst_err", 32'(err), 32'd0);
            end
            2: begin
                chk("t1_strobe3_cycles", 32'(scnt[3]), 32'd2);
                chk("t1_strobe4_cycles", 32'(scnt[4]), 32'd2);
                chk("t1_data3", data_at[3], 32'hDEADBEEF);
                chk("t1_data4", data_at[4], 32'h12345678);
                chk("t1_frame_gap", 32'(first_cyc[4] - first_cyc[3]), 32'd4);
                chk("t1_done_count", 32'(done_cnt), 32'd1);
                chk("t1_strobe_total", 32'(strobe_tot), 32'd4);
                chk("t1_err", 32'(err), 32'd0);
            end
            3: begin
                chk("t2_strobe_total", 32'(strobe_tot), 32'd0);
                chk("t2_done_count", 32'(done_cnt), 32'd0);
                chk("t2_busy", 32'(busy), 32'd0);
                chk("t2_s_ready", 32'(bus.s_ready), 32'd1);
            end
            4: begin
                chk("t3_err", 32'(err), 32'd1);
                chk("t3_strobe_total", 32'(strobe_tot), 32'd0);
                chk("t3_done_count", 32'(done_cnt), 32'd0);
                chk("t3_busy", 32'(busy), 32'd0);
            end
            5: chk("t3_err_cleared", 32'(err), 32'd0);
            6: begin
                chk("t4_err", 32'(err), 32'd1);
                chk("t4_busy", 32'(busy), 32'd0);
            end
            7: begin
                chk("t4_strobe0_cycles", 32'(scnt[0]), 32'd2);
                chk("t4_data0", data_at[0], 32'hCAFEF00D);
                chk("t4_done_count", 32'(done_cnt), 32'd1);
            end
            8: chk("clr_vs_new_err", 32'(err), 32'd1);
            9: begin
                chk("stall_busy", 32'(busy), 32'd1);
                chk("stall_strobe", 32'(FrameStrobe), 32'd0);
                chk("stall_s_ready", 32'(bus.s_ready), 32'd1);
            end
            10: begin
                chk("stall_strobe7_cycles", 32'(scnt[7]), 32'd2);
                chk("stall_strobe8_cycles", 32'(scnt[8]), 32'd2);
                chk("stall_data8", data_at[8], 32'h22222222);
                chk("stall_done_count", 32'(done_cnt), 32'd1);
            end
            11: begin
                chk("midrst_strobe", 32'(FrameStrobe), 32'd0);
                chk("midrst_data", FrameData, 32'd0);
                chk("midrst_busy", 32'(busy), 32'd0);
                chk("midrst_strobe10_cycles", 32'(scnt[10]), 32'd1);
            end
            12: begin
                chk("postrst_strobe1_cycles", 32'(scnt[1]), 32'd2);
                chk("postrst_strobe2_cycles", 32'(scnt[2]), 32'd2);
                chk("postrst_data2", data_at[2], 32'h55555555);
                chk("postrst_done_count", 32'(done_cnt), 32'd1);
            end
            13: begin
                chk("n0_done_count", 32'(done_cnt), 32'd1);
                chk("n0_strobe_total", 32'(strobe_tot), 32'd0);
                chk("n0_busy", 32'(busy), 32'd0);
            end
            default: ;
        endcase
    endtask

    always @(negedge CLK) begin
        cyc++;
        if (chk_en) begin
            chk("s_ready", 32'(bus.s_ready), 32'(m_ready));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
            chk("FrameData", FrameData, m_data);
            chk("FrameStrobe", 32'(FrameStrobe), 32'(m_strobe));
            for (int i = 0; i < int'(NF); i++) begin
                if (m_strobe[i]) begin
                    scnt[i]++;
                    strobe_tot++;
                    data_at[i] = m_data;
                    if (first_cyc[i] < 0) first_cyc[i] = cyc;
                end
            end
            if (m_done) done_cnt++;
        end
        if (to_req != to_seen) begin
            to_seen = to_req;
            checks++;
            errors++;
            $display("FAIL wait_bound: got expired expected completed");
        end
        if (pin_req != pin_seen) begin
            pin_seen = pin_req;
            do_pin(pin_id);
        end
    end

    task automatic pin(input int id);
        @(posedge CLK); #3;
        pin_id = id;
        pin_req++;
    endtask

    task automatic send(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge CLK);
            if (m_ready) ok = 1'b1;
            @(posedge CLK); #3;
        end
        bus.s_valid = 1'b0;
        if (!ok) to_req++;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while ((m_busy || !m_ready) && k < 300);
        if (k >= 300) to_req++;
        @(posedge CLK); #3;
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        for (int i = 0; i < int'(NF); i++) begin
            scnt[i] = 0; first_cyc[i] = -1; data_at[i] = '0;
        end
        @(posedge CLK); #3;
        chk_en = 1'b1;
        repeat (2) begin @(posedge CLK); #3; end
        pin(1);
        resetn = 1'b1;

        // Two frames into column 0 starting at frame 3
        pin(0);
        send(32'hA0003002);
        send(32'hDEADBEEF);
        send(32'h12345678);
        wait_idle();
        pin(2);

        // Group addressed to column 5 is skipped
        pin(0);
        send(32'hA0500003);
        send(32'h01010101);
        send(32'h02020202);
        send(32'h03030303);
        wait_idle();
        pin(3);

        // start 18 + 3 frames overruns 20 lines
        pin(0);
        send(32'hA0012003);
        send(32'hAAAA0001);
        send(32'hAAAA0002);
        send(32'hAAAA0003);
        wait_idle();
        pin(4);
        err_clr = 1'b1;
        @(posedge CLK); #3;
        err_clr = 1'b0;
        pin(5);

        // Bad magic, then a normal header
        pin(0);
        send(32'h50003001);
        pin(6);
        send(32'hA0000001);
        send(32'hCAFEF00D);
        wait_idle();
        pin(7);

        // Clear and a new error in the same cycle
        err_clr = 1'b1;
        send(32'h5FFFFFFF);
        err_clr = 1'b0;
        pin(8);

        // Source stalls between data words
        pin(0);
        send(32'hA0007002);
        send(32'h11111111);
        repeat (10) begin @(posedge CLK); #3; end
        pin(9);
        send(32'h22222222);
        wait_idle();
        pin(10);

        // Reset while frame 10 is strobing
        pin(0);
        send(32'hA000A001);
        send(32'h33333333);
        resetn = 1'b0;
        pin(11);
        resetn = 1'b1;
        pin(0);
        send(32'hA0001002);
        send(32'h44444444);
        send(32'h55555555);
        wait_idle();
        pin(12);

        // Empty group completes immediately
        pin(0);
        send(32'hA0005000);
        wait_idle();
        pin(13);

        repeat (3) begin @(posedge CLK); #3; end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
